// File: rtl/interim_buffer_mp_pkg.sv
// Shared defaults and bus-packing helpers for the multi-read-port interim buffer.
package interim_buffer_mp_pkg;

   localparam int DEF_ADDR_LEN = 6;
   localparam int DEF_DATA_LEN = 32;
   localparam int DEF_NUM_RD   = 2;

   // Low bit index of port p inside a packed bus of w-bit lanes.
   function automatic int port_lo(input int p, input int w);
      return p * w;
   endfunction

endpackage

// File: rtl/interim_rd_port.sv
// One read port of the interim buffer: write bypass compare, data mux,
// 1-cycle output register with stall/rd_en hold rules, and consume reporting.
//
// Handshake: data_out_v high means data_out carries a word that was valid
// (stored or bypassed) when the read issued. There is no backpressure; the
// consumer samples data_out whenever data_out_v is high. stall freezes the
// port only while rd_en stays high; dropping rd_en clears data_out_v.
module interim_rd_port #(
   parameter int ADDR_LEN = 6,
   parameter int DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic                stall,
   input  logic [ADDR_LEN-1:0] rd_addr,
   input  logic                wrt_en,
   input  logic [ADDR_LEN-1:0] wrt_addr,
   input  logic [DATA_LEN-1:0] wrt_data,
   input  logic [DATA_LEN-1:0] mem_data,
   input  logic                mem_valid,
   output logic [DATA_LEN-1:0] data_out,
   output logic                data_out_v,
   output logic                consume_hit,
   output logic                bypass_hit
);

   logic bypass;
   logic fire;

   assign bypass      = wrt_en && (wrt_addr == rd_addr);
   assign fire        = rd_en && !stall;
   assign consume_hit = fire && (bypass || mem_valid);
   assign bypass_hit  = fire && bypass;

   // Valid flag: cleared when idle, frozen under stall, else follows the hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_v <= 1'b0;
      end else if (!rd_en) begin
         data_out_v <= 1'b0;
      end else if (!stall) begin
         data_out_v <= bypass || mem_valid;
      end
   end

   // Data register is not reset; it only loads on an unstalled read.
   always_ff @(posedge clk) begin
      if (fire) begin
         data_out <= bypass ? wrt_data : mem_data;
      end
   end

endmodule

// File: rtl/interim_buffer_mp.sv
// Multi-read-port interim buffer: storage, per-entry valid bitmap with flush
// and optional consume-on-read, registered occupancy and sticky overwrite error.
module interim_buffer_mp
   import interim_buffer_mp_pkg::*;
#(
   parameter int ADDR_LEN        = DEF_ADDR_LEN,
   parameter int DATA_LEN        = DEF_DATA_LEN,
   parameter int NUM_RD          = DEF_NUM_RD,
   parameter int CONSUME_ON_READ = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wrt_en,
   input  logic [ADDR_LEN-1:0]        wrt_addr,
   input  logic [DATA_LEN-1:0]        wrt_data,
   input  logic                       stall,
   input  logic                       interim_invalid,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_LEN-1:0] rd_addr,
   output logic [NUM_RD*DATA_LEN-1:0] data_out,
   output logic [NUM_RD-1:0]          data_out_v,
   output logic [ADDR_LEN:0]          occupancy,
   output logic                       overwrite_err
);

   localparam int DEPTH = 1 << ADDR_LEN;

   logic [DATA_LEN-1:0] mem [DEPTH];
   logic [DEPTH-1:0]    valid;
   logic [DEPTH-1:0]    valid_nxt;
   logic [DEPTH-1:0]    consume_mask;
   logic                byp_consume;
   logic [ADDR_LEN:0]   occ_nxt;
   logic                err_set;
   logic                err_q;

   logic [ADDR_LEN-1:0] port_addr [NUM_RD];
   logic [NUM_RD-1:0]   port_hit;
   logic [NUM_RD-1:0]   port_byp;

   genvar p;
   generate
      for (p = 0; p < NUM_RD; p++) begin : g_rd
         assign port_addr[p] = rd_addr[port_lo(p, ADDR_LEN) +: ADDR_LEN];

         interim_rd_port #(
            .ADDR_LEN (ADDR_LEN),
            .DATA_LEN (DATA_LEN)
         ) u_port (
            .clk         (clk),
            .rst         (rst),
            .rd_en       (rd_en[p]),
            .stall       (stall),
            .rd_addr     (port_addr[p]),
            .wrt_en      (wrt_en),
            .wrt_addr    (wrt_addr),
            .wrt_data    (wrt_data),
            .mem_data    (mem[port_addr[p]]),
            .mem_valid   (valid[port_addr[p]]),
            .data_out    (data_out[port_lo(p, DATA_LEN) +: DATA_LEN]),
            .data_out_v  (data_out_v[p]),
            .consume_hit (port_hit[p]),
            .bypass_hit  (port_byp[p])
         );
      end
   endgenerate

   // Storage write; writes are never blocked by stall.
   always_ff @(posedge clk) begin
      if (wrt_en) begin
         mem[wrt_addr] <= wrt_data;
      end
   end

   // Next valid bitmap: consume, then flush, then write on top; a bypassed
   // consume is the only case where the fresh write ends invalid.
   always_comb begin
      consume_mask = '0;
      byp_consume  = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         if ((CONSUME_ON_READ != 0) && port_hit[i]) begin
            consume_mask[port_addr[i]] = 1'b1;
            if (port_byp[i]) begin
               byp_consume = 1'b1;
            end
         end
      end
      valid_nxt = valid & ~consume_mask;
      if (interim_invalid) begin
         valid_nxt = '0;
      end
      if (wrt_en) begin
         valid_nxt[wrt_addr] = !byp_consume;
      end
   end

   // Population count of the next bitmap feeds the occupancy register.
   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_nxt = occ_nxt + {{ADDR_LEN{1'b0}}, valid_nxt[i]};
      end
   end

   // Overwriting a live entry that nobody consumed or flushed loses data.
   assign err_set = (CONSUME_ON_READ != 0) && wrt_en && valid[wrt_addr] &&
                    !consume_mask[wrt_addr] && !interim_invalid;

   // Bitmap, occupancy and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid     <= '0;
         occupancy <= '0;
         err_q     <= 1'b0;
      end else begin
         valid     <= valid_nxt;
         occupancy <= occ_nxt;
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   assign overwrite_err = (CONSUME_ON_READ != 0) ? err_q : 1'b0;

endmodule

// File: tb/tb_interim_buffer_mp.sv
// Directed bench for interim_buffer_mp: plain instance plus a consume-on-read
// instance sharing one stimulus set.
module tb_interim_buffer_mp;

   localparam int AL = 6;
   localparam int DL = 32;
   localparam int NR = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           wrt_en = 1'b0;
   logic [AL-1:0]  wrt_addr = '0;
   logic [DL-1:0]  wrt_data = '0;
   logic           stall = 1'b0;
   logic           interim_invalid = 1'b0;
   logic [NR-1:0]  rd_en = '0;
   logic [NR*AL-1:0] rd_addr = '0;

   logic [NR*DL-1:0] data_out, data_out_c;
   logic [NR-1:0]    data_out_v, data_out_v_c;
   logic [AL:0]      occupancy, occupancy_c;
   logic             overwrite_err, overwrite_err_c;

   int n_checks = 0;
   int n_errors = 0;

   interim_buffer_mp #(.ADDR_LEN(AL), .DATA_LEN(DL), .NUM_RD(NR), .CONSUME_ON_READ(0)) dut (
      .clk(clk), .rst(rst), .wrt_en(wrt_en), .wrt_addr(wrt_addr), .wrt_data(wrt_data),
      .stall(stall), .interim_invalid(interim_invalid), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(data_out), .data_out_v(data_out_v), .occupancy(occupancy),
      .overwrite_err(overwrite_err));

   interim_buffer_mp #(.ADDR_LEN(AL), .DATA_LEN(DL), .NUM_RD(NR), .CONSUME_ON_READ(1)) dut_c (
      .clk(clk), .rst(rst), .wrt_en(wrt_en), .wrt_addr(wrt_addr), .wrt_data(wrt_data),
      .stall(stall), .interim_invalid(interim_invalid), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(data_out_c), .data_out_v(data_out_v_c), .occupancy(occupancy_c),
      .overwrite_err(overwrite_err_c));

   // Clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic en, input logic [AL-1:0] a);
      rd_en[p] = en;
      rd_addr[p*AL +: AL] = a;
   endtask

   task automatic do_write(input logic en, input logic [AL-1:0] a, input logic [DL-1:0] d);
      wrt_en = en;
      wrt_addr = a;
      wrt_data = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   function automatic logic [DL-1:0] lane(input logic [NR*DL-1:0] bus, input int p);
      return bus[p*DL +: DL];
   endfunction

   initial begin
      // ---------------- reset state
      step();
      step();
      check_eq("rst_v", 64'(data_out_v), 64'h0);
      check_eq("rst_occ", 64'(occupancy), 64'h0);
      check_eq("rst_err_c", 64'(overwrite_err_c), 64'h0);
      rst = 1'b0;

      // ---------------- read of empty buffer
      set_rd(0, 1'b1, 6'd5);
      step();
      check_eq("empty_v0", 64'(data_out_v[0]), 64'h0);
      check_eq("empty_occ", 64'(occupancy), 64'h0);
      set_rd(0, 1'b0, 6'd0);

      // ---------------- write then dual-port read
      do_write(1'b1, 6'd3, 32'hDEAD_BEEF);
      step();
      do_write(1'b0, 6'd0, 32'h0);
      set_rd(0, 1'b1, 6'd3);
      set_rd(1, 1'b1, 6'd3);
      step();
      check_eq("dual_d0", 64'(lane(data_out, 0)), 64'hDEAD_BEEF);
      check_eq("dual_d1", 64'(lane(data_out, 1)), 64'hDEAD_BEEF);
      check_eq("dual_v", 64'(data_out_v), 64'h3);
      check_eq("dual_occ", 64'(occupancy), 64'h1);

      // ---------------- write-to-read bypass on port 1
      set_rd(0, 1'b0, 6'd0);
      set_rd(1, 1'b1, 6'd7);
      do_write(1'b1, 6'd7, 32'h1234);
      step();
      do_write(1'b0, 6'd0, 32'h0);
      check_eq("byp_d1", 64'(lane(data_out, 1)), 64'h1234);
      check_eq("byp_v", 64'(data_out_v), 64'h2);
      check_eq("byp_occ", 64'(occupancy), 64'h2);

      // ---------------- stall hold with changing address
      set_rd(1, 1'b0, 6'd0);
      set_rd(0, 1'b1, 6'd3);
      step();
      check_eq("pre_stall_d0", 64'(lane(data_out, 0)), 64'hDEAD_BEEF);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_rd(0, 1'b1, (i == 0) ? 6'd7 : (i == 1) ? 6'd5 : 6'd0);
         step();
         check_eq($sformatf("stall_d0_%0d", i), 64'(lane(data_out, 0)), 64'hDEAD_BEEF);
         check_eq($sformatf("stall_v0_%0d", i), 64'(data_out_v[0]), 64'h1);
      end
      set_rd(0, 1'b0, 6'd7);
      step();
      check_eq("stall_drop_v0", 64'(data_out_v[0]), 64'h0);
      check_eq("stall_drop_d0", 64'(lane(data_out, 0)), 64'hDEAD_BEEF);
      stall = 1'b0;

      // ---------------- consume-on-read instance
      do_reset();
      do_write(1'b1, 6'd9, 32'hAA);
      step();
      do_write(1'b0, 6'd0, 32'h0);
      check_eq("cons_occ_1", 64'(occupancy_c), 64'h1);
      set_rd(0, 1'b1, 6'd9);
      step();
      check_eq("cons_rd1_v", 64'(data_out_v_c[0]), 64'h1);
      check_eq("cons_rd1_d", 64'(lane(data_out_c, 0)), 64'hAA);
      check_eq("cons_occ_0", 64'(occupancy_c), 64'h0);
      step();
      check_eq("cons_rd2_v", 64'(data_out_v_c[0]), 64'h0);
      set_rd(0, 1'b0, 6'd0);
      do_write(1'b1, 6'd2, 32'h55);
      step();
      check_eq("ovw_err_first", 64'(overwrite_err_c), 64'h0);
      do_write(1'b1, 6'd2, 32'h66);
      step();
      do_write(1'b0, 6'd0, 32'h0);
      check_eq("ovw_err_set", 64'(overwrite_err_c), 64'h1);
      check_eq("ovw_err_plain", 64'(overwrite_err), 64'h0);
      // bypassed read consumes the fresh write
      do_write(1'b1, 6'd4, 32'h44);
      set_rd(0, 1'b1, 6'd4);
      step();
      do_write(1'b0, 6'd0, 32'h0);
      check_eq("byp_cons_v", 64'(data_out_v_c[0]), 64'h1);
      check_eq("byp_cons_d", 64'(lane(data_out_c, 0)), 64'h44);
      check_eq("byp_cons_occ", 64'(occupancy_c), 64'h1);
      step();
      check_eq("byp_cons_rd2_v", 64'(data_out_v_c[0]), 64'h0);
      check_eq("ovw_err_sticky", 64'(overwrite_err_c), 64'h1);
      set_rd(0, 1'b0, 6'd0);

      // ---------------- flush with same-cycle write
      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_write(1'b1, 6'(i), 32'h100 + 32'(i));
         step();
      end
      check_eq("fill_occ", 64'(occupancy), 64'h4);
      interim_invalid = 1'b1;
      do_write(1'b1, 6'd10, 32'hA10);
      set_rd(0, 1'b1, 6'd2);
      set_rd(1, 1'b1, 6'd10);
      step();
      interim_invalid = 1'b0;
      do_write(1'b0, 6'd0, 32'h0);
      check_eq("flush_cyc_v", 64'(data_out_v), 64'h3);
      check_eq("flush_cyc_d0", 64'(lane(data_out, 0)), 64'h102);
      check_eq("flush_cyc_d1", 64'(lane(data_out, 1)), 64'hA10);
      check_eq("flush_occ", 64'(occupancy), 64'h1);
      set_rd(0, 1'b1, 6'd0);
      set_rd(1, 1'b1, 6'd1);
      step();
      check_eq("flush_v_01", 64'(data_out_v), 64'h0);
      set_rd(0, 1'b1, 6'd2);
      set_rd(1, 1'b1, 6'd3);
      step();
      check_eq("flush_v_23", 64'(data_out_v), 64'h0);
      set_rd(0, 1'b1, 6'd10);
      set_rd(1, 1'b0, 6'd0);
      step();
      check_eq("flush_v_10", 64'(data_out_v), 64'h1);
      check_eq("flush_d_10", 64'(lane(data_out, 0)), 64'hA10);

      // ---------------- asynchronous reset mid-stream
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_v", 64'(data_out_v), 64'h0);
      check_eq("async_rst_occ", 64'(occupancy), 64'h0);
      check_eq("async_rst_err_c", 64'(overwrite_err_c), 64'h0);
      set_rd(0, 1'b0, 6'd0);
      step();
      rst = 1'b0;
      set_rd(0, 1'b1, 6'd10);
      step();
      check_eq("post_rst_v", 64'(data_out_v[0]), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
